// File: rtl/alu_nbit_seq.sv
// alu_nbit_seq: registered ALU with a valid/ready stream interface, persistent carry/borrow
// flags for multi-word arithmetic, barrel shifts and an iterative shift-add multiplier.
module alu_nbit_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             borrow,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             busy
);
  localparam int SW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
    OP_XOR  = 4'h4, OP_NOT  = 4'h5, OP_SLL = 4'h6, OP_SRL = 4'h7,
    OP_SRA  = 4'h8, OP_ROL  = 4'h9, OP_ADC = 4'hA, OP_SBB = 4'hB,
    OP_MUL  = 4'hC, OP_MULH = 4'hD, OP_CMP = 4'hE, OP_CLRF = 4'hF
  } op_e;

  typedef enum logic {S_IDLE, S_MULT} state_e;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             carry;
    logic             borrow;
    logic             overflow;
    logic             zero;
    logic             negative;
  } res_t;

  state_e           state, state_nxt;
  res_t             res_q, alu, mul;
  logic             out_valid_q;
  logic             cf, bf, cf_nxt, bf_nxt;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0] mplier;
  logic [SW:0]      cnt;
  logic             mul_high;
  logic             accept, is_mul, mul_done;

  logic [SW-1:0]    amt;
  logic             add_cin, sub_cin;
  logic [WIDTH:0]   add_sum, sub_sum, sll_v, srl_v, sra_v;
  logic [WIDTH-1:0] rol_y;

  assign busy      = (state == S_MULT);
  assign in_ready  = rst_n & ~busy & (~out_valid_q | out_ready);
  assign accept    = in_valid & in_ready;
  assign is_mul    = (sel == OP_MUL) || (sel == OP_MULH);
  assign mul_done  = busy && (cnt == (SW+1)'(WIDTH));

  assign out_valid = out_valid_q;
  assign y         = res_q.y;
  assign carry     = res_q.carry;
  assign borrow    = res_q.borrow;
  assign overflow  = res_q.overflow;
  assign zero      = res_q.zero;
  assign negative  = res_q.negative;

  // Subtraction is A + ~B + cin; cin = 1 for plain SUB/CMP and ~bf for SBB.
  assign amt     = b[SW-1:0];
  assign add_cin = (sel == OP_ADC) ? cf : 1'b0;
  assign sub_cin = (sel == OP_SBB) ? ~bf : 1'b1;
  assign add_sum = {1'b0, a} + {1'b0, b}  + {{WIDTH{1'b0}}, add_cin};
  assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, sub_cin};

  // One extra bit beside the operand catches the last bit shifted out as the carry.
  assign sll_v = {1'b0, a} << amt;
  assign srl_v = {a, 1'b0} >> amt;
  assign sra_v = $unsigned($signed({a, 1'b0}) >>> amt);
  assign rol_y = (a << amt) | (a >> (WIDTH - int'(amt)));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    alu    = '0;
    cf_nxt = cf;
    bf_nxt = bf;
    case (sel)
      OP_ADD, OP_ADC: begin
        alu.y        = add_sum[MSB:0];
        alu.carry    = add_sum[WIDTH];
        alu.overflow = (a[MSB] == b[MSB]) && (add_sum[MSB] != a[MSB]);
        cf_nxt       = add_sum[WIDTH];
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        alu.y        = (sel == OP_CMP) ? '0 : sub_sum[MSB:0];
        alu.borrow   = ~sub_sum[WIDTH];
        alu.overflow = (a[MSB] != b[MSB]) && (sub_sum[MSB] != a[MSB]);
        bf_nxt       = ~sub_sum[WIDTH];
      end
      OP_AND: alu.y = a & b;
      OP_OR:  alu.y = a | b;
      OP_XOR: alu.y = a ^ b;
      OP_NOT: alu.y = ~a;
      OP_SLL: begin
        {alu.carry, alu.y} = sll_v;
        cf_nxt             = sll_v[WIDTH];
      end
      OP_SRL: begin
        {alu.y, alu.carry} = srl_v;
        cf_nxt             = srl_v[0];
      end
      OP_SRA: begin
        {alu.y, alu.carry} = sra_v;
        cf_nxt             = sra_v[0];
      end
      OP_ROL: begin
        alu.y     = rol_y;
        alu.carry = (amt != '0) & rol_y[0];
        cf_nxt    = (amt != '0) & rol_y[0];
      end
      OP_CLRF: begin
        cf_nxt = 1'b0;
        bf_nxt = 1'b0;
      end
      default: ;
    endcase
    // CMP reports zero/negative of the difference even though y is forced to zero.
    if (sel == OP_CMP) begin
      alu.zero     = (sub_sum[MSB:0] == '0);
      alu.negative = sub_sum[MSB];
    end else begin
      alu.zero     = (alu.y == '0);
      alu.negative = alu.y[MSB];
    end
  end

  always_comb begin
    mul          = '0;
    mul.y        = mul_high ? acc[2*WIDTH-1:WIDTH] : acc[MSB:0];
    mul.carry    = !mul_high && (acc[2*WIDTH-1:WIDTH] != '0);
    mul.zero     = (mul.y == '0);
    mul.negative = mul.y[MSB];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && is_mul) state_nxt = S_MULT;
      S_MULT:  if (mul_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q       <= '0;
      out_valid_q <= 1'b0;
      cf          <= 1'b0;
      bf          <= 1'b0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      cnt         <= '0;
      mul_high    <= 1'b0;
    end else begin
      if (accept) begin
        cf <= cf_nxt;
        bf <= bf_nxt;
        if (is_mul) begin
          acc         <= '0;
          mcand       <= {{WIDTH{1'b0}}, a};
          mplier      <= b;
          cnt         <= '0;
          mul_high    <= (sel == OP_MULH);
          out_valid_q <= 1'b0;
        end else begin
          res_q       <= alu;
          out_valid_q <= 1'b1;
        end
      end else if (mul_done) begin
        res_q       <= mul;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (busy && !mul_done) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + (SW+1)'(1);
      end
    end
  end

endmodule

// File: doc/alu_nbit_seq.md
# alu_nbit_seq

Registered, parametrised-width ALU with a valid/ready stream interface, persistent carry/borrow flags for multi-word arithmetic, barrel shifts by an operand-supplied amount, and an iterative shift-add multiplier. It is the datapath execution unit behind the sequencer and register file. Single-cycle ops stream at one per clock, and MUL/MULH stall the input for WIDTH cycles.

## Interface
- WIDTH, 16, operand/result width; power of two, ≥4; SW = $clog2(WIDTH)
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset: one clock; reset is synchronous and active-low
- in_valid  in  1  operation presented
- in_ready  out  1  = rst_n & !busy & (!out_valid | out_ready)
- a, b  in  WIDTH  operands; shift amount = b[SW-1:0]
- sel  in  4  opcode
- out_valid  out  1  result registers hold an unconsumed result
- out_ready  in  1  consumer accepts result
- y  out  WIDTH  result
- carry, borrow, overflow, zero, negative  out  1 each  registered result flags
- busy  out  1  multiplier iterating

## Operation
- Accept = in_valid & in_ready. Operands/opcode are sampled on the accept edge.
- Opcodes:
  - 0000 ADD, 0001 SUB (A+~B+1; borrow = ~carry-out), 0010 AND, 0011 OR, 0100 XOR, 0101 NOT A
  - 0110 SLL, 0111 SRL, 1000 SRA, 1001 ROL, each by amt = b[SW-1:0]
  - 1010 ADC (A+B+cf), 1011 SBB (A−B−bf), 1100 MUL (low WIDTH bits of unsigned A×B), 1101 MULH (high WIDTH bits)
  - 1110 CMP, 1111 CLRF
- Internal flag registers cf, bf:
  - ADD/ADC/shifts write cf := carry.
  - SUB/SBB/CMP write bf := borrow.
  - CLRF clears both.
  - Logic ops and MUL/MULH leave cf/bf unchanged.
- Flags:
  - overflow is signed overflow for ADD/ADC/SUB/SBB/CMP and 0 otherwise.
  - carry is 0 for ops not listed above, except MUL: carry = (high half ≠ 0).
  - borrow is 0 except for SUB/SBB/CMP.
- Shifts:
  - amt=0 gives y=A, carry=0.
  - SLL carry = A[WIDTH−amt]; SRL/SRA carry = A[amt−1]; ROL carry = A[WIDTH−amt] (= new y[0]).
  - SRA fills with A[WIDTH−1].
- CMP: y=0. zero = (A−B == 0), negative = MSB of (A−B); flags come from the difference, not from y.
- CLRF: y=0, all output flags 0, zero=1.
- All other ops: zero = (y==0), negative = y[WIDTH−1].
- MUL/MULH FSM, states IDLE → MULT → IDLE:
  - Accept latches A, B and sets busy; state MULT with counter = 0 and a 2·WIDTH accumulator.
  - Each MULT cycle adds the shifted multiplicand when the current multiplier bit is 1, then increments the counter.
  - After WIDTH iterations: load y/flags, set out_valid, clear busy, return to IDLE.
- Output hold: while out_valid & !out_ready, y and all flags are held stable.
- Reset (rst_n=0 at an edge):
  - y=0, all flags 0, out_valid=0, busy=0, cf=bf=0, FSM=IDLE.
  - in_ready=0 while rst_n is low.
  - An in-flight multiply is discarded; no result is emitted.

## Timing
- Single-cycle op accepted at edge N: result and flags visible, out_valid=1, after edge N.
- Throughput is 1 op/cycle when out_ready=1.
- ADC/SBB accepted at N+1 use the cf/bf written at N (back-to-back chaining supported).
- MUL/MULH accepted at N: busy=1 after N; out_valid=1 after edge N+WIDTH+1.
- in_ready=0 from acceptance until out_valid rises, then follows out_ready.
- Result consumed and new op accepted on the same edge: out_valid stays 1 and registers reload (no bubble).
- out_valid falls only on the edge where out_ready=1 and there is no new accept.
- in_valid/sel changes while in_ready=0 have no effect.
- cf/bf update on the accept edge, independent of output backpressure.

## Test plan
- ADD FFFF+0001, then ADC 0000+0000 (WIDTH=16):
  - first result: y=0000, carry=1, zero=1, one cycle after accept
  - second result: y=0001, carry=0
- SUB 8000−0001, then CMP 0003 vs 0005:
  - SUB: y=7FFF, overflow=1, borrow=0
  - CMP: y=0000, borrow=1, zero=0, negative=1
- Shifts:
  - SRA 8008 by 4 → y=F800, carry=1
  - SLL 00FF by 0 → y=00FF, carry=0
  - ROL 8001 by 1 → y=0003, carry=1
- MUL 0100×0100:
  - y=0000, carry=1, out_valid 17 edges after accept, in_ready=0 throughout
  - MULH with the same operands → y=0001
- Backpressure: hold out_ready=0 for 3 cycles after an ADD result.
  - y and flags are stable, in_ready=0, no op is lost.
  - Then with out_ready=1, 4 ADDs stream with results on 4 consecutive cycles.
- Reset mid-multiply: assert rst_n=0 for 1 cycle at iteration 5.
  - out_valid stays 0 and cf=bf=0.
  - in_ready=1 the cycle after release.
  - The next ADD produces a correct result.
